// File: rtl/udm_bus_pkg.sv
// Shared types and widths for the 32-bit MemSplit32 req/ack/resp split bus.
// Used by the arbiter and by other blocks that sit on the same bus.
package udm_bus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  typedef logic [0:0] master_id_t;

  localparam master_id_t MID_M0 = 1'b0;
  localparam master_id_t MID_M1 = 1'b1;

  typedef struct packed {
    logic               we;
    logic [BUS_AW-1:0]  addr;
    logic [BUS_DW-1:0]  wdata;
    logic [BUS_BEW-1:0] be;
  } bus_req_t;

endpackage

// File: rtl/udm_bus_arbiter_rr_tag_fifo.sv
// Small synchronous FIFO that holds the issuing master ID of each in-flight read.
// Head entry is always visible on dout_o; push when full and pop when empty are ignored.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (cnt_q == CNT_W'(DEPTH));
    empty_o  = (cnt_q == '0);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/udm_bus_arbiter_rr.sv
// Two-master round-robin arbiter onto one MemSplit32 slave; read responses are
// steered back to their issuer using an in-order tag FIFO.
module udm_bus_arbiter_rr
  import udm_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk_i,
  input  logic               arst_n_i,

  input  logic               m0_req_i,
  input  logic               m0_we_i,
  input  logic [BUS_AW-1:0]  m0_addr_bi,
  input  logic [BUS_DW-1:0]  m0_wdata_bi,
  input  logic [BUS_BEW-1:0] m0_be_bi,
  output logic               m0_ack_o,
  output logic               m0_resp_o,
  output logic [BUS_DW-1:0]  m0_rdata_bo,

  input  logic               m1_req_i,
  input  logic               m1_we_i,
  input  logic [BUS_AW-1:0]  m1_addr_bi,
  input  logic [BUS_DW-1:0]  m1_wdata_bi,
  input  logic [BUS_BEW-1:0] m1_be_bi,
  output logic               m1_ack_o,
  output logic               m1_resp_o,
  output logic [BUS_DW-1:0]  m1_rdata_bo,

  output logic               s_req_o,
  output logic               s_we_o,
  output logic [BUS_AW-1:0]  s_addr_bo,
  output logic [BUS_DW-1:0]  s_wdata_bo,
  output logic [BUS_BEW-1:0] s_be_bo,
  input  logic               s_ack_i,
  input  logic               s_resp_i,
  input  logic [BUS_DW-1:0]  s_rdata_bi,

  output logic               rsp_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  bus_req_t   m0_bus, m1_bus, s_bus;
  logic       elig0, elig1, gnt0, gnt1, gnt_any;
  logic       xfer, push, pop;
  master_id_t gnt_id, head_id;
  master_id_t prio_q, prio_d;
  logic       rsp_err_q, rsp_err_d;
  logic       fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count_unused;

  assign m0_bus = '{we: m0_we_i, addr: m0_addr_bi, wdata: m0_wdata_bi, be: m0_be_bi};
  assign m1_bus = '{we: m1_we_i, addr: m1_addr_bi, wdata: m1_wdata_bi, be: m1_be_bi};

  always_comb begin
    // Full is taken from the registered count, so a same-cycle pop never unblocks a read
    elig0     = m0_req_i && !(!m0_we_i && fifo_full);
    elig1     = m1_req_i && !(!m1_we_i && fifo_full);
    gnt0      = elig0 && (!elig1 || (prio_q == MID_M0));
    gnt1      = elig1 && !gnt0;
    gnt_any   = gnt0 || gnt1;
    gnt_id    = gnt1 ? MID_M1 : MID_M0;
    s_bus     = gnt1 ? m1_bus : (gnt0 ? m0_bus : '0);
    xfer      = gnt_any && s_ack_i;
    push      = xfer && !s_bus.we;
    pop       = s_resp_i && !fifo_empty;
    prio_d    = xfer ? ~gnt_id : prio_q;
    rsp_err_d = rsp_err_q || (s_resp_i && fifo_empty);
  end

  tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push_i   (push),
    .din_i    (gnt_id),
    .pop_i    (pop),
    .dout_o   (head_id),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count_unused)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prio_q    <= MID_M0;
      rsp_err_q <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign s_req_o    = gnt_any;
  assign s_we_o     = s_bus.we;
  assign s_addr_bo  = s_bus.addr;
  assign s_wdata_bo = s_bus.wdata;
  assign s_be_bo    = s_bus.be;

  assign m0_ack_o    = gnt0 && s_ack_i;
  assign m1_ack_o    = gnt1 && s_ack_i;
  assign m0_resp_o   = pop && (head_id == MID_M0);
  assign m1_resp_o   = pop && (head_id == MID_M1);
  assign m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
  assign m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_udm_bus_arbiter_rr.sv
// Directed bench for udm_bus_arbiter_rr: inputs change on the falling edge,
// outputs are sampled 1ns later, state commits on the following rising edge.
module tb_udm_bus_arbiter_rr;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ack, s_resp;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        rsp_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [31:0] A0 = 32'h0000_0004;
  localparam logic [31:0] A1 = 32'h8000_0000;
  localparam logic [31:0] D0 = 32'h1111_0004;
  localparam logic [31:0] D1 = 32'h2222_8000;

  always #5 clk = ~clk;

  udm_bus_arbiter_rr #(.MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_wdata_bi(m0_wdata),
    .m0_be_bi(m0_be), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_wdata_bi(m1_wdata),
    .m1_be_bi(m1_be), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_wdata_bo(s_wdata), .s_be_bo(s_be),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
    .rsp_err_o(rsp_err)
  );

  task automatic drive_idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    s_ack = 0; s_resp = 0; s_rdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    arst_n = 0;
    #3 arst_n = 1;
  endtask

  task automatic test_reset();
    drive_idle();
    arst_n = 0;
    #1;
    vec_cnt++; if (s_req !== 1'b0) begin err_cnt++; $display("FAIL rst_s_req got=%b exp=0", s_req); end
    vec_cnt++; if ({m0_ack, m1_ack} !== 2'b00) begin err_cnt++; $display("FAIL rst_acks got=%b exp=00", {m0_ack, m1_ack}); end
    vec_cnt++; if ({m0_resp, m1_resp} !== 2'b00) begin err_cnt++; $display("FAIL rst_resps got=%b exp=00", {m0_resp, m1_resp}); end
    vec_cnt++; if (rsp_err !== 1'b0) begin err_cnt++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
    vec_cnt++; if (dut.u_fifo.count_o !== 3'd0) begin err_cnt++; $display("FAIL rst_count got=%0d exp=0", dut.u_fifo.count_o); end
    vec_cnt++; if (s_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_s_addr got=%h exp=0", s_addr); end
    #3 arst_n = 1;
  endtask

  task automatic test_write();
    apply_reset();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_wdata = 32'h0000_1234; m0_be = 4'hF; s_ack = 1;
    #1;
    vec_cnt++; if (s_req !== 1'b1 || s_we !== 1'b1) begin err_cnt++; $display("FAIL wr_s_req_we got=%b%b exp=11", s_req, s_we); end
    vec_cnt++; if (s_addr !== 32'h0) begin err_cnt++; $display("FAIL wr_s_addr got=%h exp=0", s_addr); end
    vec_cnt++; if (s_wdata !== 32'h0000_1234) begin err_cnt++; $display("FAIL wr_s_wdata got=%h exp=00001234", s_wdata); end
    vec_cnt++; if (s_be !== 4'hF) begin err_cnt++; $display("FAIL wr_s_be got=%h exp=f", s_be); end
    vec_cnt++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin err_cnt++; $display("FAIL wr_acks got=%b%b exp=10", m0_ack, m1_ack); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (dut.u_fifo.count_o !== 3'd0) begin err_cnt++; $display("FAIL wr_count got=%0d exp=0", dut.u_fifo.count_o); end
    vec_cnt++; if (s_req !== 1'b0) begin err_cnt++; $display("FAIL wr_idle_s_req got=%b exp=0", s_req); end
  endtask

  task automatic test_alternate();
    logic [31:0] exp_d;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m0_req = (k < 4); m0_we = 0; m0_addr = A0; m0_be = 4'hF;
      m1_req = (k < 4); m1_we = 0; m1_addr = A1; m1_be = 4'hF;
      s_ack  = (k < 4);
      s_resp = (k > 0);
      exp_d  = (((k - 1) % 2) == 1) ? D1 : D0;
      s_rdata = (k > 0) ? exp_d : 32'h0;
      #1;
      if (k < 4) begin
        vec_cnt++;
        if (m0_ack !== ((k % 2) == 0) || m1_ack !== ((k % 2) == 1)) begin
          err_cnt++; $display("FAIL alt_ack k=%0d got=%b%b exp_m1=%0d", k, m0_ack, m1_ack, k % 2);
        end
        vec_cnt++;
        if (s_addr !== (((k % 2) == 1) ? A1 : A0)) begin
          err_cnt++; $display("FAIL alt_s_addr k=%0d got=%h", k, s_addr);
        end
      end
      if (k > 0) begin
        vec_cnt++;
        if (m0_resp !== (((k - 1) % 2) == 0) || m1_resp !== (((k - 1) % 2) == 1)) begin
          err_cnt++; $display("FAIL alt_resp k=%0d got=%b%b", k, m0_resp, m1_resp);
        end
        vec_cnt++;
        if ((((k - 1) % 2) == 1 ? m1_rdata : m0_rdata) !== exp_d) begin
          err_cnt++; $display("FAIL alt_rdata k=%0d got0=%h got1=%h exp=%h", k, m0_rdata, m1_rdata, exp_d);
        end
      end
    end
  endtask

  task automatic test_full();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 32'h10; s_ack = 1;
      #1;
      vec_cnt++; if (m0_ack !== 1'b1) begin err_cnt++; $display("FAIL full_ack c=%0d got=%b exp=1", c, m0_ack); end
    end
    @(negedge clk);
    #1;
    vec_cnt++; if (m0_ack !== 1'b0 || s_req !== 1'b0) begin err_cnt++; $display("FAIL full_blocked got ack=%b sreq=%b exp=0", m0_ack, s_req); end
    vec_cnt++; if (dut.u_fifo.count_o !== 3'd4) begin err_cnt++; $display("FAIL full_count got=%0d exp=4", dut.u_fifo.count_o); end
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_addr = 32'h0; m1_wdata = 32'h77; m1_be = 4'h3;
    #1;
    vec_cnt++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin err_cnt++; $display("FAIL full_wr_pass got=%b%b exp=01", m0_ack, m1_ack); end
    @(negedge clk);
    m1_req = 0; s_resp = 1; s_rdata = 32'h0BAD_0001;
    #1;
    vec_cnt++; if (m0_ack !== 1'b0) begin err_cnt++; $display("FAIL full_pop_same_cycle got=%b exp=0", m0_ack); end
    vec_cnt++; if (m0_resp !== 1'b1 || m0_rdata !== 32'h0BAD_0001) begin err_cnt++; $display("FAIL full_resp got=%b %h exp=1 0bad0001", m0_resp, m0_rdata); end
    @(negedge clk);
    s_resp = 0; s_rdata = '0;
    #1;
    vec_cnt++; if (m0_ack !== 1'b1) begin err_cnt++; $display("FAIL full_fifth_ack got=%b exp=1", m0_ack); end
    vec_cnt++; if (dut.u_fifo.count_o !== 3'd3) begin err_cnt++; $display("FAIL full_count3 got=%0d exp=3", dut.u_fifo.count_o); end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (dut.u_fifo.count_o !== 3'd4) begin err_cnt++; $display("FAIL full_count4 got=%0d exp=4", dut.u_fifo.count_o); end
  endtask

  task automatic test_unsolicited();
    apply_reset();
    @(negedge clk);
    s_resp = 1; s_rdata = 32'hDEAD_BEEF;
    #1;
    vec_cnt++; if ({m0_resp, m1_resp} !== 2'b00) begin err_cnt++; $display("FAIL uns_resp got=%b exp=00", {m0_resp, m1_resp}); end
    vec_cnt++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin err_cnt++; $display("FAIL uns_rdata got=%h %h exp=0", m0_rdata, m1_rdata); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      s_resp = 0; s_rdata = '0;
      #1;
      vec_cnt++; if (rsp_err !== 1'b1) begin err_cnt++; $display("FAIL uns_err_sticky c=%0d got=%b exp=1", c, rsp_err); end
    end
    arst_n = 0;
    #1;
    vec_cnt++; if (rsp_err !== 1'b0) begin err_cnt++; $display("FAIL uns_err_clear got=%b exp=0", rsp_err); end
    #2 arst_n = 1;
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_d;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = A0;
      m1_req = 1; m1_we = 0; m1_addr = A1; s_ack = 1;
      #1;
      vec_cnt++; if (m0_ack !== ((c % 2) == 0) || m1_ack !== ((c % 2) == 1)) begin err_cnt++; $display("FAIL pp_fill c=%0d got=%b%b", c, m0_ack, m1_ack); end
    end
    @(negedge clk);
    m0_req = 0; s_resp = 1; s_rdata = 32'hCAFE_0001;
    #1;
    vec_cnt++; if (dut.u_fifo.count_o !== 3'd3) begin err_cnt++; $display("FAIL pp_count_pre got=%0d exp=3", dut.u_fifo.count_o); end
    vec_cnt++; if (m1_ack !== 1'b1) begin err_cnt++; $display("FAIL pp_m1_ack got=%b exp=1", m1_ack); end
    vec_cnt++; if (m0_resp !== 1'b1 || m1_resp !== 1'b0 || m0_rdata !== 32'hCAFE_0001) begin
      err_cnt++; $display("FAIL pp_resp got=%b%b %h exp=10 cafe0001", m0_resp, m1_resp, m0_rdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      m1_req = 0; s_ack = 0; s_resp = 1;
      exp_d = 32'hCAFE_0002 + c;
      s_rdata = exp_d;
      #1;
      if (c == 0) begin
        vec_cnt++; if (dut.u_fifo.count_o !== 3'd3) begin err_cnt++; $display("FAIL pp_count_post got=%0d exp=3", dut.u_fifo.count_o); end
      end
      vec_cnt++; if (m1_resp !== ((c % 2) == 0) || m0_resp !== ((c % 2) == 1)) begin err_cnt++; $display("FAIL pp_order c=%0d got=%b%b", c, m0_resp, m1_resp); end
      vec_cnt++; if (((c % 2) == 0 ? m1_rdata : m0_rdata) !== exp_d) begin err_cnt++; $display("FAIL pp_data c=%0d got0=%h got1=%h exp=%h", c, m0_rdata, m1_rdata, exp_d); end
    end
    @(negedge clk);
    drive_idle();
    #1;
    vec_cnt++; if (dut.u_fifo.count_o !== 3'd0) begin err_cnt++; $display("FAIL pp_drained got=%0d exp=0", dut.u_fifo.count_o); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = A0; s_ack = 1;
    @(negedge clk);
    m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = A1;
    @(negedge clk);
    m1_req = 0; m0_req = 1; m0_we = 1; m0_wdata = 32'h5;
    @(negedge clk);
    m0_req = 1; m0_we = 0; m1_req = 1; m1_we = 0;
    #1;
    vec_cnt++; if (dut.u_fifo.count_o !== 3'd2) begin err_cnt++; $display("FAIL mid_count_pre got=%0d exp=2", dut.u_fifo.count_o); end
    vec_cnt++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin err_cnt++; $display("FAIL mid_prio_pre got=%b%b exp=01", m0_ack, m1_ack); end
    #1 arst_n = 0;
    #1;
    vec_cnt++; if (dut.u_fifo.count_o !== 3'd0) begin err_cnt++; $display("FAIL mid_flush got=%0d exp=0", dut.u_fifo.count_o); end
    vec_cnt++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin err_cnt++; $display("FAIL mid_prio_rst got=%b%b exp=10", m0_ack, m1_ack); end
    m0_req = 0; m1_req = 0; s_ack = 0;
    #1;
    vec_cnt++; if (s_req !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin err_cnt++; $display("FAIL mid_outputs got=%b%b%b exp=000", s_req, m0_ack, m1_ack); end
    @(negedge clk);
    arst_n = 1;
    @(negedge clk);
    s_resp = 1; s_rdata = 32'h0000_0055;
    #1;
    vec_cnt++; if ({m0_resp, m1_resp} !== 2'b00) begin err_cnt++; $display("FAIL mid_late_resp got=%b exp=00", {m0_resp, m1_resp}); end
    @(negedge clk);
    s_resp = 0; s_rdata = '0;
    #1;
    vec_cnt++; if (rsp_err !== 1'b1) begin err_cnt++; $display("FAIL mid_err got=%b exp=1", rsp_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_alternate();
    test_full();
    test_unsolicited();
    test_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
